record_sequencer: RTL and testbench

Controller that sequences one serial recording channel. It arms on a start command and optionally waits for a trigger. It then drives the sample strobe and enable into the channel's record unit at a programmed rate, collects the 32-bit words the unit assembles, and forwards them downstream through a one-deep valid/ready output register. It sits between the channel's register/control interface and the record unit, and owns word counting, completion and overflow reporting.

---
 rtl/record_pkg.sv | 13 +
 rtl/record_sequencer_sample_divider.sv | 39 +++
 rtl/record_sequencer.sv | 131 +++++++++++++
 tb/tb_record_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/record_pkg.sv
// rtl/record_pkg.sv - shared types and constants for the record sequencer
package record_pkg;
    localparam int WORD_W  = 32;
    localparam int DIV_MIN = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        DRAIN,
        DONE
    } recState_t;
endpackage

// File: rtl/record_sequencer_sample_divider.sv
// rtl/record_sequencer_sample_divider.sv - sample-rate divider, one registered pulse every div cycles
module sample_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             pulse
);
    localparam logic [DIV_W-1:0] ONE = 1;

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] divLast;

    assign divLast = div - ONE;

    // Pulse is registered off the terminal count, so it lands div cycles after the first enabled cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            pulse <= 1'b0;
        end else if (clear) begin
            count <= '0;
            pulse <= 1'b0;
        end else if (enable) begin
            if (count == divLast) begin
                count <= '0;
                pulse <= 1'b1;
            end else begin
                count <= count + ONE;
                pulse <= 1'b0;
            end
        end else begin
            pulse <= 1'b0;
        end
    end
endmodule

// File: rtl/record_sequencer.sv
// rtl/record_sequencer.sv - sequences one recording channel: arm, trigger, sample, buffer, report
module record_sequencer
    import record_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              trigMode,
    input  logic              trigger,
    input  logic [DIV_W-1:0]  divisor,
    input  logic [CNT_W-1:0]  numWords,
    output logic              recEnable,
    output logic              samplePulse,
    input  logic [WORD_W-1:0] recWord,
    input  logic              recValid,
    output logic [WORD_W-1:0] mOutData,
    output logic              mOutValid,
    input  logic              mOutReady,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  wordsSent
);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);

    recState_t        state, stateNext;
    logic [DIV_W-1:0] divQ;
    logic [CNT_W-1:0] numWordsQ;
    logic             recValidQ, triggerQ;
    logic             recEdge, trigEdge, outFree;
    logic             startTaken, loadWord, dropWord, lastLoad;
    logic             divPulse;

    assign recEdge    = recValid & ~recValidQ;
    assign trigEdge   = trigger & ~triggerQ;
    assign outFree    = ~mOutValid | mOutReady;
    assign startTaken = (state == IDLE) & start & ~abort;
    assign loadWord   = (state == RUN) & recEdge & outFree & ~abort;
    assign dropWord   = (state == RUN) & recEdge & ~outFree & ~abort;
    assign lastLoad   = loadWord & ((wordsSent + CNT_ONE) == numWordsQ);

    sample_divider #(
        .DIV_W (DIV_W)
    ) uDivider (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != RUN),
        .enable (state == RUN),
        .div    (divQ),
        .pulse  (divPulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        recEnable   = 1'b0;
        samplePulse = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (numWords == '0) stateNext = DONE;
                    else                stateNext = trigMode ? ARM : RUN;
                end
            end
            ARM: begin
                if (trigEdge) stateNext = RUN;
            end
            RUN: begin
                recEnable   = 1'b1;
                samplePulse = divPulse;
                if (lastLoad) stateNext = DRAIN;
            end
            DRAIN: begin
                if (outFree) stateNext = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (abort) stateNext = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recValidQ <= 1'b0;
            triggerQ  <= 1'b0;
            divQ      <= DIV_FLOOR;
            numWordsQ <= '0;
            mOutData  <= '0;
            mOutValid <= 1'b0;
            overflow  <= 1'b0;
            wordsSent <= '0;
        end else begin
            recValidQ <= recValid;
            triggerQ  <= trigger;
            if (startTaken) begin
                divQ      <= (divisor < DIV_FLOOR) ? DIV_FLOOR : divisor;
                numWordsQ <= numWords;
                overflow  <= 1'b0;
                wordsSent <= '0;
            end
            // mOutData only moves on a load, and loads only happen when the register is free.
            if (abort) begin
                mOutValid <= 1'b0;
            end else if (loadWord) begin
                mOutData  <= recWord;
                mOutValid <= 1'b1;
                if (wordsSent != {CNT_W{1'b1}}) wordsSent <= wordsSent + CNT_ONE;
            end else if (mOutValid && mOutReady) begin
                mOutValid <= 1'b0;
            end
            if (dropWord) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_record_sequencer.sv
// tb/tb_record_sequencer.sv - scoreboard bench for record_sequencer
module tb_record_sequencer;
    localparam int DIV_W = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0, abort = 1'b0, trigMode = 1'b0, trigger = 1'b0;
    logic [DIV_W-1:0] divisor = '0;
    logic [CNT_W-1:0] numWords = '0;
    logic [31:0]      recWord = '0;
    logic             recValid = 1'b0, mOutReady = 1'b0;
    logic             recEnable, samplePulse, mOutValid, busy, done, overflow;
    logic [31:0]      mOutData;
    logic [CNT_W-1:0] wordsSent;

    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    logic [31:0] expQ[$];
    int          pulseTimes[$];
    bit          sawValid = 1'b0;

    record_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .trigMode(trigMode), .trigger(trigger), .divisor(divisor), .numWords(numWords),
        .recEnable(recEnable), .samplePulse(samplePulse), .recWord(recWord), .recValid(recValid),
        .mOutData(mOutData), .mOutValid(mOutValid), .mOutReady(mOutReady),
        .busy(busy), .done(done), .overflow(overflow), .wordsSent(wordsSent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (samplePulse) pulseTimes.push_back(cycle);
        if (mOutValid) sawValid = 1'b1;
        if (!reset && mOutValid && mOutReady) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL out_word: actual %0h required none", mOutData);
            end else begin
                check("out_word", mOutData, expQ.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doStart(input int d, input int n, input bit tm);
        divisor  = DIV_W'(d);
        numWords = CNT_W'(n);
        trigMode = tm;
        start    = 1'b1;
        pulseTimes.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input bit push);
        recWord  = w;
        recValid = 1'b1;
        if (push) expQ.push_back(w);
        tick();
        recValid = 1'b0;
    endtask

    task automatic waitPulse(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (samplePulse) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic waitDone(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                check(name, done, 1);
                return;
            end
        end
        check({name, "_timeout"}, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t1Words [3];
        bit ok;
        int e, a, bad;
        t1Words = '{32'hA5A5A5A5, 32'h00000001, 32'hFFFFFFFF};

        // reset state, during and after reset
        repeat (2) tick();
        check("rst_flags", {recEnable, samplePulse, mOutValid, busy, done, overflow}, 0);
        check("rst_data", mOutData, 0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("rst_flags_after", {recEnable, samplePulse, mOutValid, busy, done, overflow}, 0);
        check("rst_words", wordsSent, 0);

        // basic capture: div 4, three words, ready high
        tick();
        mOutReady = 1'b1;
        doStart(4, 3, 0);
        @(negedge clk);
        e = cycle;
        check("t1_busy", busy, 1);
        check("t1_recEnable", recEnable, 1);
        for (int i = 0; i < 3; i++) begin
            waitPulse(ok);
            check("t1_pulse_seen", ok, 1);
            tick();
            sendWord(t1Words[i], 1);
        end
        @(negedge clk);
        check("t1_last_valid", mOutValid, 1);
        check("t1_no_early_done", done, 0);
        tick();
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_words", wordsSent, 3);
        check("t1_overflow", overflow, 0);
        check("t1_pulse_count", pulseTimes.size(), 3);
        if (pulseTimes.size() >= 3) begin
            check("t1_first_pulse", pulseTimes[0] - e, 4);
            check("t1_period_a", pulseTimes[1] - pulseTimes[0], 4);
            check("t1_period_b", pulseTimes[2] - pulseTimes[1], 4);
        end
        tick();
        @(negedge clk);
        check("t1_idle", {busy, done}, 0);

        // triggered capture
        tick();
        trigger = 1'b0;
        doStart(4, 1, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (samplePulse || recEnable || !busy) bad++;
        end
        check("t2_arm_quiet", bad, 0);
        tick();
        trigger = 1'b1;
        a = cycle;
        tick();
        @(negedge clk);
        check("t2_run", recEnable, 1);
        waitPulse(ok);
        check("t2_pulse_seen", ok, 1);
        if (pulseTimes.size() >= 1) check("t2_first_pulse", pulseTimes[0] - a, 5);
        tick();
        trigger = 1'b0;
        sendWord(32'h0BADF00D, 1);
        waitDone("t2_done");

        // overflow while output stalled
        tick();
        mOutReady = 1'b0;
        doStart(2, 3, 0);
        tick();
        sendWord(32'h11110001, 1);
        tick();
        sendWord(32'h22220002, 0);
        @(negedge clk);
        check("t3_overflow", overflow, 1);
        check("t3_words", wordsSent, 1);
        check("t3_busy", busy, 1);
        repeat (3) tick();
        @(negedge clk);
        check("t3_hold_data", mOutData, 32'h11110001);
        check("t3_hold_valid", mOutValid, 1);
        tick();
        mOutReady = 1'b1;
        tick();
        sendWord(32'h33330003, 1);
        tick();
        sendWord(32'h44440004, 1);
        waitDone("t3_done");
        check("t3_words_final", wordsSent, 3);
        check("t3_overflow_sticky", overflow, 1);

        // zero-length capture
        tick();
        sawValid = 1'b0;
        doStart(4, 0, 0);
        @(negedge clk);
        check("t4_done", done, 1);
        repeat (5) tick();
        @(negedge clk);
        check("t4_no_pulses", pulseTimes.size(), 0);
        check("t4_no_valid", sawValid, 0);
        check("t4_idle", busy, 0);

        // abort with a buffered word
        tick();
        mOutReady = 1'b0;
        doStart(3, 5, 0);
        tick();
        sendWord(32'hCAFE0001, 0);
        tick();
        sendWord(32'hCAFE0002, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("t5_abort_flags", {busy, mOutValid, recEnable}, 0);
        check("t5_overflow_hold", overflow, 1);
        check("t5_words_hold", wordsSent, 1);
        mOutReady = 1'b1;
        tick();
        doStart(4, 1, 0);
        @(negedge clk);
        check("t5_restart_clear", {overflow, wordsSent}, 0);
        tick();
        sendWord(32'hBEEF0001, 1);
        waitDone("t5_done");

        // degenerate divisors
        for (int d = 0; d < 2; d++) begin
            tick();
            doStart(d, 2, 0);
            @(negedge clk);
            e = cycle;
            repeat (7) @(negedge clk);
            check("t6_pulse_count", pulseTimes.size() >= 3, 1);
            if (pulseTimes.size() >= 3) begin
                check("t6_first_pulse", pulseTimes[0] - e, 2);
                check("t6_period_a", pulseTimes[1] - pulseTimes[0], 2);
                check("t6_period_b", pulseTimes[2] - pulseTimes[1], 2);
            end
            tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end

        // asynchronous reset in DRAIN
        tick();
        mOutReady = 1'b0;
        doStart(2, 1, 0);
        tick();
        sendWord(32'hD00DD00D, 0);
        @(negedge clk);
        check("t7_drain", {busy, mOutValid, recEnable}, 3'b110);
        #2 reset = 1'b1;
        #1;
        check("t7_rst_flags", {recEnable, samplePulse, mOutValid, busy, done, overflow}, 0);
        check("t7_rst_data", {mOutData, wordsSent}, 0);
        tick();
        reset = 1'b0;
        mOutReady = 1'b1;
        repeat (2) tick();

        check("queue_empty", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
